cv32e40p_data_pair_splitter: RTL
================================

// Module: cv32e40p_data_pair_splitter
// PURPOSE
// - Sits between the core LSU data port (data_*, data_*64) and a single 32-bit OBI data memory port.
// - A core request with data_req64_i=1 is a paired access. It is serialised into two OBI beats:
//   beat0 uses the data_* fields, beat1 uses the data_*64 fields.
// - The core sees one grant and one rvalid per request.
// - Responses are tracked in a beat-tag FIFO so pipelined accesses reassemble in order.
// PARAMETERS
// - DEPTH  2  max outstanding OBI beats (tag FIFO depth, >=2)
// PORTS
// - clk_i            in   1   clock
// - rst_i            in   1   synchronous active-high reset
// - data_req_i       in   1   core request, held with all fields until data_gnt_o
// - data_req64_i     in   1   request is a pair (second beat present)
// - data_we_i        in   1   beat0 write enable
// - data_be_i        in   4   beat0 byte enables
// - data_addr_i      in   32  beat0 address
// - data_wdata_i     in   32  beat0 write data
// - data_we64_i      in   1   beat1 write enable
// - data_addr64_i    in   32  beat1 address
// - data_wdata64_i   in   32  beat1 write data
// - data_gnt_o       out  1   core grant (all beats of request granted)
// - data_rvalid_o    out  1   core response (all beats returned)
// - data_rdata_o     out  32  beat0 read data
// - data_rdata64_o   out  32  beat1 read data (pair only, else 0)
// - obi_req_o        out  1   OBI request
// - obi_gnt_i        in   1   OBI grant
// - obi_addr_o       out  32  OBI address
// - obi_we_o         out  1   OBI write enable
// - obi_be_o         out  4   OBI byte enables
// - obi_wdata_o      out  32  OBI write data
// - obi_rvalid_i     in   1   OBI response valid
// - obi_rdata_i      in   32  OBI read data
// - pair_cnt_o       out  32  completed pair count (perf option)
// - stall_cnt_o      out  32  OBI stall cycles (perf option)
// BEHAVIOUR
// Reset:
// - FSM=IDLE, tag FIFO empty, hold_q=0, counters=0.
// - All outputs 0 while rst_i=1.
// Request FSM:
// - IDLE:
//   - obi_req_o = data_req_i && fifo_cnt<DEPTH; obi_* = beat0 fields.
//   - On obi_gnt_i: push tag {pair=data_req64_i, first=1}.
//     - If !data_req64_i: data_gnt_o=1 in the same cycle (combinational); stay IDLE.
//     - Else: go BEAT1, data_gnt_o=0.
// - BEAT1:
//   - obi_req_o = fifo_cnt<DEPTH; obi_addr/we/wdata = *64 fields; obi_be_o=4'hF.
//   - On obi_gnt_i: push {pair=1, first=0}, data_gnt_o=1, go IDLE.
// - obi_req_o never drops without grant once raised. The FIFO cannot fill while req is up, because
//   pops only reduce fifo_cnt.
// Response path (per obi_rvalid_i, pop tag):
// - {pair,first}=1,1: hold_q<=obi_rdata_i; data_rvalid_o=0.
// - {pair,first}=1,0: data_rvalid_o=1, data_rdata_o=hold_q, data_rdata64_o=obi_rdata_i.
// - pair=0: data_rvalid_o=1, data_rdata_o=obi_rdata_i, data_rdata64_o=0.
// - data_rdata_o is 0 when data_rvalid_o=0.
// - Latency adds 0 cycles to OBI timing: core rvalid is in the cycle of the last beat's obi_rvalid_i.
// Boundaries:
// - Push+pop in the same cycle: fifo_cnt unchanged, pointers wrap modulo DEPTH.
// - FIFO full: no new beat issued (obi_req_o=0) until a pop.
// - obi_rvalid_i with FIFO empty: ignored (protocol error, flagged by bench).
// - Reset mid-pair: FSM to IDLE, tags dropped; late rvalids after reset are ignored.
// CONFIGURATION
// - CV32E40P_DATA_SPLIT_PERF_EN defined:
//   - pair_cnt_o increments on each pair-completing data_rvalid_o.
//   - stall_cnt_o increments each cycle with obi_req_o && !obi_gnt_i.
//   - Both saturate at 32'hFFFF_FFFF; reset to 0.
// - Undefined: both outputs tied to 0, no counter flops.
// TESTING
// - Single read 0x100, gnt same cycle, rvalid next cycle, rdata=0xA5A5A5A5
//   -> data_gnt_o cycle0, data_rvalid_o cycle1, data_rdata_o=0xA5A5A5A5.
// - Pair read 0x200/0x204, rdata 0x11111111 then 0x22222222
//   -> one data_gnt_o after beat1 gnt, one data_rvalid_o, data_rdata_o=0x11111111,
//      data_rdata64_o=0x22222222.
// - Pair write, obi_gnt_i low 3 cycles on beat1
//   -> obi_addr_o stays 0x204, obi_be_o=4'hF, obi_wdata_o=data_wdata64_i,
//      data_gnt_o only after grant, stall_cnt_o=3 (perf on).
// - DEPTH=2, two singles granted, rvalid withheld
//   -> third request keeps obi_req_o=0 until first rvalid; in-order rvalids.
// - Reset asserted in BEAT1 after beat0 grant, then late obi_rvalid_i
//   -> outputs 0, no data_rvalid_o, next request starts in IDLE.
// - Perf off: pair_cnt_o=stall_cnt_o=0 throughout all above.

Source files
------------

// File: rtl/cv32e40p_data_pair_splitter.sv
// Serialises paired LSU accesses onto a single 32-bit OBI port and reassembles the responses in order.
// Define CV32E40P_DATA_SPLIT_PERF_EN to build the pair/stall performance counters.
module cv32e40p_data_pair_splitter #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_req64_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic        data_we64_i,
    input  logic [31:0] data_addr64_i,
    input  logic [31:0] data_wdata64_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic [31:0] data_rdata64_o,
    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    output logic [31:0] pair_cnt_o,
    output logic [31:0] stall_cnt_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT1 = 1'b1
    } state_e;

    typedef struct packed {
        logic pair;
        logic first;
    } tag_t;

    state_e        state_q, state_d;
    tag_t          tag_q [DEPTH];
    tag_t          tag_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hold_q, hold_d;

    logic fifo_full;
    logic beat_req;
    logic push;
    logic pop;
    tag_t push_tag;
    tag_t pop_tag;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request side: beat0 carries the data_* fields, beat1 the data_*64 fields.
    always_comb begin
        fifo_full   = (cnt_q == CW'(DEPTH));
        state_d     = state_q;
        beat_req    = 1'b0;
        push        = 1'b0;
        push_tag    = '0;
        data_gnt_o  = 1'b0;
        obi_addr_o  = data_addr_i;
        obi_we_o    = data_we_i;
        obi_be_o    = data_be_i;
        obi_wdata_o = data_wdata_i;

        unique case (state_q)
            IDLE: begin
                beat_req = data_req_i && !fifo_full;
                if (beat_req && obi_gnt_i) begin
                    push     = 1'b1;
                    push_tag = '{pair: data_req64_i, first: 1'b1};
                    if (data_req64_i) begin
                        state_d = BEAT1;
                    end else begin
                        data_gnt_o = 1'b1;
                    end
                end
            end
            BEAT1: begin
                beat_req    = !fifo_full;
                obi_addr_o  = data_addr64_i;
                obi_we_o    = data_we64_i;
                obi_be_o    = 4'hF;
                obi_wdata_o = data_wdata64_i;
                if (beat_req && obi_gnt_i) begin
                    push       = 1'b1;
                    push_tag   = '{pair: 1'b1, first: 1'b0};
                    data_gnt_o = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        obi_req_o = beat_req;
        if (rst_i) begin
            obi_req_o   = 1'b0;
            data_gnt_o  = 1'b0;
            obi_addr_o  = '0;
            obi_we_o    = 1'b0;
            obi_be_o    = '0;
            obi_wdata_o = '0;
        end
    end

    // Tag FIFO and response reassembly; rvalid with an empty FIFO is dropped.
    always_comb begin
        pop     = obi_rvalid_i && (cnt_q != '0);
        pop_tag = tag_q[rptr_q];

        tag_d = tag_q;
        if (push) begin
            tag_d[wptr_q] = push_tag;
        end
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        hold_d         = hold_q;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = '0;
        data_rdata64_o = '0;
        if (pop) begin
            if (pop_tag.pair && pop_tag.first) begin
                hold_d = obi_rdata_i;
            end else if (pop_tag.pair) begin
                data_rvalid_o  = 1'b1;
                data_rdata_o   = hold_q;
                data_rdata64_o = obi_rdata_i;
            end else begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = obi_rdata_i;
            end
        end

        if (rst_i) begin
            data_rvalid_o  = 1'b0;
            data_rdata_o   = '0;
            data_rdata64_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            tag_q   <= tag_d;
        end
    end

`ifdef CV32E40P_DATA_SPLIT_PERF_EN
    logic [31:0] pair_cnt_q, pair_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        pair_cnt_d  = pair_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (data_rvalid_o && pop_tag.pair && (pair_cnt_q != 32'hFFFF_FFFF)) begin
            pair_cnt_d = pair_cnt_q + 32'd1;
        end
        if (obi_req_o && !obi_gnt_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pair_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            pair_cnt_q  <= pair_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pair_cnt_o  = rst_i ? '0 : pair_cnt_q;
    assign stall_cnt_o = rst_i ? '0 : stall_cnt_q;
`else
    assign pair_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

endmodule
